// File: rtl/bram_pixel_fetch.sv
// bram_pixel_fetch
//   Raster read engine feeding the deskew compute stage. Walks a rectangular
//   pixel window (base, width, height, line stride), issues one-cycle read
//   strobes to the BRAM port-B interface controller, captures the returned
//   bytes into a small output FIFO and delivers them as a valid/ready stream
//   tagged with end-of-row (pix_last) and end-of-frame (pix_eof).
//
//   Handshake: a pixel transfers on a cycle where pix_valid && pix_ready are
//   both high; pix_valid never depends on pix_ready, and the pixel and tags
//   hold steady while pix_valid is high and pix_ready is low.
//
//   Ports
//     clk, rst_n               clock, asynchronous active-low reset
//     start, abort             frame request pulse / synchronous cancel
//     cfg_base/width/height/stride  window description, latched on start
//     busy, done, oob_err      status (done is a one-cycle pulse)
//     mem_en, mem_wr, mem_addr read request to the interface controller
//     mem_rdata, mem_rdata_rdy returned pixel, one cycle after mem_en
//     pix_data/last/eof/valid, pix_ready  output pixel stream
//
//   Optional feature macro: BRAM_FETCH_BOUNDS_CHECK_EN
//     When defined, addresses >= MEM_DEPTH are not read; FILL_VAL is
//     substituted in order and oob_err latches until the next start.
module bram_pixel_fetch #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int DIM_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_DEPTH  = 76800,
  parameter logic [DATA_W-1:0] FILL_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [ADDR_W-1:0] cfg_stride,
  output logic              busy,
  output logic              done,
  output logic              oob_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_rdy,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_last,
  output logic              pix_eof,
  output logic              pix_valid,
  input  logic              pix_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d, stride_q, stride_d;
  logic [DIM_W-1:0]    width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0]    col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0]    count_q, count_d, inflight_q, inflight_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                ret_last_q, ret_last_d, ret_eof_q, ret_eof_d;
  logic [DATA_W+1:0]   fifo_mem_q [FIFO_DEPTH];  // {eof, last, data}

  logic [ADDR_W-1:0]   addr;
  logic                addr_oob, credit_ok, issue, col_last, row_last;
  logic                ret, push, pop;
  logic [DATA_W-1:0]   push_data;
  logic [DATA_W+1:0]   head;

`ifdef BRAM_FETCH_BOUNDS_CHECK_EN
  // An out-of-range slot is answered locally one cycle after issue, in the
  // same slot a real read would have returned, so ordering is preserved.
  logic fill_q, fill_d, oob_err_q, oob_err_d;
  assign addr_oob  = {1'b0, addr} >= (ADDR_W+1)'(MEM_DEPTH);
  assign ret       = mem_rdata_rdy | fill_q;
  assign push_data = fill_q ? FILL_VAL : mem_rdata;
  assign oob_err   = oob_err_q;
`else
  logic unused_params;
  assign unused_params = ^{FILL_VAL, MEM_DEPTH[0]};
  assign addr_oob  = 1'b0;
  assign ret       = mem_rdata_rdy;
  assign push_data = mem_rdata;
  assign oob_err   = 1'b0;
`endif

  assign addr      = row_base_q + ADDR_W'(col_q);
  // Credit covers both buffered pixels and reads still in flight.
  assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue     = (state_q == S_FETCH) && credit_ok;
  assign col_last  = (col_q == width_q - DIM_W'(1));
  assign row_last  = (row_q == height_q - DIM_W'(1));
  // Returns while IDLE belong to an aborted frame and are dropped.
  assign push      = (state_q != S_IDLE) && ret;
  assign pop       = pix_valid && pix_ready;

  assign mem_en    = issue && !addr_oob;
  assign mem_wr    = 1'b0;
  assign mem_addr  = addr;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pix_valid = (count_q != '0);
  assign head      = fifo_mem_q[rd_ptr_q];
  assign pix_data  = pix_valid ? head[DATA_W-1:0] : '0;
  assign pix_last  = pix_valid & head[DATA_W];
  assign pix_eof   = pix_valid & head[DATA_W+1];

  always_comb begin
    state_d    = state_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    width_d    = width_q;
    height_d   = height_q;
    col_d      = col_q;
    row_d      = row_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
    ret_last_d = col_last;
    ret_eof_d  = col_last && row_last;
`ifdef BRAM_FETCH_BOUNDS_CHECK_EN
    fill_d     = issue && addr_oob;
    oob_err_d  = oob_err_q | (issue && addr_oob);
`endif
    if (abort) begin
      state_d    = S_IDLE;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = '0;
`ifdef BRAM_FETCH_BOUNDS_CHECK_EN
      fill_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          inflight_d = '0;
          if (start) begin
            row_base_d = cfg_base;
            stride_d   = cfg_stride;
            width_d    = cfg_width;
            height_d   = cfg_height;
            col_d      = '0;
            row_d      = '0;
`ifdef BRAM_FETCH_BOUNDS_CHECK_EN
            oob_err_d  = 1'b0;
`endif
            state_d = ((cfg_width == '0) || (cfg_height == '0)) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (issue) begin
            if (col_last) begin
              col_d      = '0;
              row_base_d = row_base_q + stride_q;
              row_d      = row_q + DIM_W'(1);
              if (row_last) state_d = S_DRAIN;
            end else begin
              col_d = col_q + DIM_W'(1);
            end
          end
        end
        // Next-cycle counts are used so done follows the final pop directly.
        S_DRAIN: if ((count_d == '0) && (inflight_d == '0)) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_base_q <= '0;
      stride_q   <= '0;
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ret_last_q <= 1'b0;
      ret_eof_q  <= 1'b0;
`ifdef BRAM_FETCH_BOUNDS_CHECK_EN
      fill_q     <= 1'b0;
      oob_err_q  <= 1'b0;
`endif
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      width_q    <= width_d;
      height_q   <= height_d;
      col_q      <= col_d;
      row_q      <= row_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ret_last_q <= ret_last_d;
      ret_eof_q  <= ret_eof_d;
`ifdef BRAM_FETCH_BOUNDS_CHECK_EN
      fill_q     <= fill_d;
      oob_err_q  <= oob_err_d;
`endif
      if (push) fifo_mem_q[wr_ptr_q] <= {ret_eof_q, ret_last_q, push_data};
    end
  end

  // Credit accounting makes a push into a full FIFO impossible.
  push_not_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: doc/bram_pixel_fetch.md
Name: bram_pixel_fetch

Overview:
- Raster read engine that sits directly upstream of the BRAM port-B interface controller in the deskew datapath.
- Walks a rectangular pixel window (base, width, height, line stride), issues one-cycle read strobes with addresses to the interface controller, and captures returned bytes on its read-ready pulse.
- Delivers the pixels as a valid/ready stream tagged with end-of-row and end-of-frame flags to the deskew compute stage.
- Read-only; the memory write strobe is held low.

Parameters:
ADDR_W, 17, BRAM address width
DATA_W, 8, pixel width
DIM_W, 10, width/height counter width
FIFO_DEPTH, 4, output buffer entries (power of 2, >=2)
MEM_DEPTH, 76800, valid word count; used only with the optional feature
FILL_VAL, 8'h00, substitute pixel for out-of-range addresses; used only with the optional feature

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  frame request pulse; ignored while busy
abort  in  1  synchronous cancel
cfg_base  in  ADDR_W  first pixel address
cfg_width  in  DIM_W  pixels per row
cfg_height  in  DIM_W  rows
cfg_stride  in  ADDR_W  address step between row starts
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
oob_err  out  1  sticky out-of-range flag (optional feature)
mem_en  out  1  read strobe to interface controller
mem_wr  out  1  constant 0
mem_addr  out  ADDR_W  read address
mem_rdata  in  DATA_W  returned pixel
mem_rdata_rdy  in  1  high exactly one cycle after an accepted mem_en; mem_rdata valid that cycle
pix_data  out  DATA_W  stream pixel
pix_last  out  1  last pixel of a row
pix_eof  out  1  last pixel of the frame
pix_valid  out  1  stream valid
pix_ready  in  1  stream ready

Behaviour:
- Reset: async on rst_n low. State = IDLE; FIFO and in-flight counter cleared. busy, done, oob_err, mem_en, pix_valid, pix_last, pix_eof = 0. mem_addr = 0. pix_data = 0.
- Clock enable is implicit (free-running).
- Config: cfg_* latched on the accepted start edge; changes afterwards have no effect.
- FSM:
  - IDLE: on start, go to FETCH. If cfg_width==0 or cfg_height==0, go to DONE instead.
  - FETCH: issue reads; after the last pixel is issued, go to DRAIN.
  - DRAIN: wait until FIFO count==0 and in-flight==0, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy is still high in DONE.
- Issue rule (FETCH only): mem_en=1 in a cycle iff fifo_count + inflight < FIFO_DEPTH. No pop look-ahead.
  - mem_en and mem_addr are combinational from state and counters. mem_wr=0 always.
- Address generation:
  - addr = row_base + col, sum modulo 2^ADDR_W (wraps).
  - col increments on each issue.
  - When col==width-1: col<=0, row_base<=row_base+stride (mod 2^ADDR_W), row++.
- Tag pipe: last/eof flags are computed at issue time and delayed one cycle to align with mem_rdata_rdy.
  - In-flight counter: +1 on issue, -1 on rdata_rdy. Simultaneous issue and return leaves it unchanged.
- FIFO:
  - Push on mem_rdata_rdy; pop on pix_valid & pix_ready.
  - Simultaneous push/pop allowed when count is 1..DEPTH-1.
  - Overflow cannot occur by construction; a push while full is an assertion failure.
  - pix_valid = count!=0. Outputs are driven from the FIFO head.
- Latency: start sampled at edge T, first mem_en in cycle T+1, mem_rdata_rdy in T+2, pix_valid in T+3.
  - With pix_ready held high, throughput is 1 pixel/cycle.
- Frame end: pix_eof and pix_last are both high on the final pixel. done rises the cycle after the final pop.
- abort (highest priority after reset), any state:
  - Next cycle: IDLE, FIFO flushed, pix_valid=0, done not asserted.
  - Read data returning in the cycle after abort is discarded.
  - start in the same cycle as abort is ignored.
- Reset mid-frame: immediate return to reset values; no residual outputs.

Optional Feature:
BRAM_FETCH_BOUNDS_CHECK_EN
- Defined:
  - An address >= MEM_DEPTH is not issued (mem_en stays 0 for it). FILL_VAL is pushed into the FIFO one cycle later with the correct tags; it consumes credit like a real read.
  - oob_err is set and stays high until the next accepted start or reset.
  - Ordering of pixels is preserved.
- Undefined: no comparison logic, addresses wrap, oob_err tied 0.

Test Plan:
- Basic frame: base=0x00100, width=4, height=2, stride=8, pix_ready=1 -> mem_addr sequence 0x100,0x101,0x102,0x103,0x108,0x109,0x10A,0x10B on consecutive cycles T+1..T+8. Pixels appear T+3..T+10. pix_last on 4th and 8th; pix_eof on 8th only; done at T+11.
- Backpressure: same frame, pix_ready=0 from start -> exactly 4 mem_en pulses, then mem_en=0 and pix_valid stays 1 with pix_data = byte at 0x100. Release ready -> all 8 bytes delivered in order, none lost or duplicated.
- Zero size: width=0, height=3 -> no mem_en, no pix_valid, done pulse at T+1, busy high T+1 only.
- Address wrap: base=0x1FFFE, width=4, height=1 (macro off) -> addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Abort: assert abort after 3 pixels are popped of a 4x2 frame -> next cycle busy=0, pix_valid=0, no done. A following start runs a full frame correctly.
- Bounds (macro on, MEM_DEPTH=76800): base=76798, width=4 -> addresses 76798 and 76799 issued; last two pixels = 8'h00; oob_err=1 and stays high until the next start.
